// File: rtl/veda_mem_pkg.sv
// rtl/veda_mem_pkg.sv - shared constants and types for the veda memory copier
package veda_mem_pkg;

   localparam int AW    = 6;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;

   localparam logic OP_COPY = 1'b0;
   localparam logic OP_FILL = 1'b1;

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, FILL, FIN} state_t;

endpackage

// File: rtl/veda_addr_step.sv
// rtl/veda_addr_step.sv - wrap-around address pointer with load, increment and decrement
module veda_addr_step #(
   parameter int AW = veda_mem_pkg::AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic [AW-1:0] i_load_val,
   input  logic          i_step,
   input  logic          i_down,
   output logic [AW-1:0] o_ptr
);

   logic [AW-1:0] r_ptr;

   // Natural AW-bit overflow gives the mod 2**AW wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_load) begin
         r_ptr <= i_load_val;
      end else if (i_step) begin
         r_ptr <= i_down ? r_ptr - AW'(1) : r_ptr + AW'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/veda_mem_copier.sv
// rtl/veda_mem_copier.sv - command-driven block copy / fill engine for one veda memory port
module veda_mem_copier #(
   parameter int AW     = veda_mem_pkg::AW,
   parameter int DW     = veda_mem_pkg::DW,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          op,
   input  logic [AW-1:0] src,
   input  logic [AW-1:0] dst,
   input  logic [AW:0]   len,
   input  logic [DW-1:0] fill_val,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW:0]   words_done,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr_a,
   output logic [AW-1:0] mem_addr_b,
   output logic [DW-1:0] mem_data_in,
   output logic          mem_mode,
   input  logic [DW-1:0] mem_data_out
);

   import veda_mem_pkg::*;

   localparam int          L_DEPTH   = 1 << AW;
   localparam logic [AW:0] L_LEN_MAX = (AW+1)'(L_DEPTH);

   state_t        r_state, w_next;
   logic [AW:0]   r_len, w_len_c, r_words_done;
   logic [AW-1:0] w_diff, w_rd_base, w_wr_base, w_rd_ptr, w_wr_ptr;
   logic [DW-1:0] r_buf;
   logic [1:0]    r_wait_cnt;
   logic          r_desc, r_mem_we, r_busy, r_done, r_err, r_mode;
   logic          w_desc, w_reject, w_load, w_step_rd, w_step_wr, w_cap;
   logic          w_err_n, w_wd_inc, w_wait_last, w_last_word;

   assign w_len_c  = (len > L_LEN_MAX) ? L_LEN_MAX : len;
   assign w_diff   = dst - src;
   // Destination overlapping above the source must be copied top-down.
   assign w_desc   = (op == OP_COPY) && (w_diff != '0) && ({1'b0, w_diff} < w_len_c);
   assign w_reject = (op == OP_COPY) && (w_len_c == L_LEN_MAX) && (src != dst);
   assign w_rd_base = w_desc ? src + w_len_c[AW-1:0] - AW'(1) : src;
   assign w_wr_base = w_desc ? dst + w_len_c[AW-1:0] - AW'(1) : dst;

   assign w_wait_last = ({30'd0, r_wait_cnt} == 32'(RD_LAT - 1));
   assign w_last_word = ((r_words_done + (AW+1)'(1)) == r_len);

   always_comb begin
      w_next    = r_state;
      w_load    = 1'b0;
      w_step_rd = 1'b0;
      w_step_wr = 1'b0;
      w_cap     = 1'b0;
      w_err_n   = 1'b0;
      w_wd_inc  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load = 1'b1;
               if (w_len_c == '0) begin
                  w_next = FIN;
               end else if (w_reject) begin
                  w_next  = FIN;
                  w_err_n = 1'b1;
               end else if (op == OP_FILL) begin
                  w_next = FILL;
               end else begin
                  w_next = RD;
               end
            end
         end
         RD:   w_next = WAIT;
         WAIT: begin
            if (w_wait_last) begin
               w_cap  = 1'b1;
               w_next = WR;
            end
         end
         WR: begin
            w_step_rd = 1'b1;
            w_step_wr = 1'b1;
            w_wd_inc  = 1'b1;
            w_next    = w_last_word ? FIN : RD;
         end
         FILL: begin
            w_step_wr = 1'b1;
            w_wd_inc  = 1'b1;
            if (w_last_word) w_next = FIN;
         end
         FIN:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_len        <= '0;
         r_desc       <= 1'b0;
         r_buf        <= '0;
         r_wait_cnt   <= '0;
         r_words_done <= '0;
         r_mem_we     <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_mode       <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_mode     <= 1'b1;
         r_mem_we   <= (w_next == WR) || (w_next == FILL);
         r_busy     <= (w_next != IDLE) && (w_next != FIN);
         r_done     <= (w_next == FIN);
         r_err      <= w_err_n;
         r_wait_cnt <= (r_state == WAIT && w_next == WAIT) ? r_wait_cnt + 2'd1 : 2'd0;
         if (w_load) begin
            r_len        <= w_len_c;
            r_desc       <= w_desc;
            r_buf        <= fill_val;
            r_words_done <= '0;
         end else begin
            if (w_cap)    r_buf        <= mem_data_out;
            if (w_wd_inc) r_words_done <= r_words_done + (AW+1)'(1);
         end
      end
   end

   veda_addr_step #(.AW(AW)) u_rd_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_rd_base),
      .i_step     (w_step_rd),
      .i_down     (r_desc),
      .o_ptr      (w_rd_ptr)
   );

   veda_addr_step #(.AW(AW)) u_wr_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_wr_base),
      .i_step     (w_step_wr),
      .i_down     (r_desc),
      .o_ptr      (w_wr_ptr)
   );

   assign busy        = r_busy;
   assign done        = r_done;
   assign err         = r_err;
   assign words_done  = r_words_done;
   assign mem_we      = r_mem_we;
   assign mem_addr_a  = w_wr_ptr;
   assign mem_addr_b  = w_rd_ptr;
   assign mem_data_in = r_buf;
   assign mem_mode    = r_mode;

endmodule

// File: doc/veda_mem_copier.md
Name: veda_mem_copier

Overview:
- Command-driven engine on the initiator side of the 64x8 veda memory port.
- Drives the memory's write-enable, address, data and mode inputs, and consumes its read data.
- Two commands: block copy (read src run, write dst run) and block fill (write a constant run).
- Sits between the host control logic and one veda_mem_2 instance.

Parameters:
- AW, 6, address width; memory depth is 2**AW = 64.
- DW, 8, data width.
- RD_LAT, 1, cycles from mem_addr_b being sampled to mem_data_out valid; range 1..3.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- op  in  1  0 = copy, 1 = fill.
- src  in  AW  copy source base address.
- dst  in  AW  destination base address (copy and fill).
- len  in  AW+1  word count, 0..64; values above 64 clamp to 64.
- fill_val  in  DW  fill data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse, together with done, when a command is rejected.
- words_done  out  AW+1  count of words written for the current/last command.
- mem_we  out  1  memory write enable.
- mem_addr_a  out  AW  memory write address.
- mem_addr_b  out  AW  memory read address.
- mem_data_in  out  DW  memory write data.
- mem_mode  out  1  memory mode select; tied to 1 (port-b read mode) whenever out of reset.
- mem_data_out  in  DW  memory read data.

Behaviour:
- Reset: all outputs registered and 0 (mem_mode = 0 only while rst is high); state = IDLE. Reset mid-command aborts it: mem_we is 0 from the next cycle, with no done or err pulse.
- Memory contract: a write occurs on an edge with mem_we = 1 to mem_addr_a. Read data for mem_addr_b is valid RD_LAT cycles after the edge that samples the address.
- States: IDLE, RD, WAIT, WR, FILL, FIN.
- IDLE: start = 1 latches op, src, dst, clamped len and fill_val.
  - len = 0 goes to FIN.
  - copy with len = 64 and src != dst: rejected; goes to FIN with err set.
  - copy otherwise goes to RD; fill goes to FILL.
  - start outside IDLE is ignored.
- Copy direction:
  - descending when ((dst - src) mod 64) is in 1..len-1, i.e. the destination overlaps above the source. Pointers then start at src+len-1 and dst+len-1 and decrement.
  - otherwise ascending from src and dst.
  - all address arithmetic wraps mod 64.
- RD: drive mem_addr_b = read pointer, then go to WAIT.
- WAIT: hold mem_addr_b for RD_LAT cycles. Capture mem_data_out into the data buffer on the last WAIT cycle, then go to WR.
- WR: mem_we = 1, mem_addr_a = write pointer, mem_data_in = buffer. Step both pointers and increment words_done. If words_done reaches len go to FIN, else go to RD.
- Copy throughput: 2 + RD_LAT cycles per word.
- FILL: mem_we = 1, mem_data_in = fill_val, mem_addr_a = dst + i ascending. Writes one word per cycle; goes to FIN after len words.
- FIN: done = 1 (err = 1 if rejected) for one cycle, busy = 0, then IDLE.
- busy is low in IDLE and FIN.
- words_done clears on command accept and holds its value after done.
- mem_we is low in every state except WR and FILL.

Decomposition:
- Shared package veda_mem_pkg holds:
  - AW, DW and DEPTH constants.
  - state enum {IDLE, RD, WAIT, WR, FILL, FIN}.
  - op encodings OP_COPY = 0, OP_FILL = 1.
- One sub-module, veda_addr_step: a wrap-around pointer that loads, increments or decrements mod 2**AW. It is instantiated twice (read and write pointers).

Test Plan:
- Fill with dst = 20, len = 4, fill_val = 0x55 → mem_we high 4 consecutive cycles on addresses 20..23; done 5 cycles after accept; words_done = 4; read-back of 20..23 = 0x55.
- Preload 20..22 = 0x11, 0x22, 0x33; copy src = 20, dst = 40, len = 3 with RD_LAT = 1 → 40..42 = 0x11, 0x22, 0x33; done 10 cycles after accept; ascending order.
- Overlap: preload 20..23 = 1, 2, 3, 4; copy src = 20, dst = 22, len = 4 → write order 25, 24, 23, 22; final 22..25 = 1, 2, 3, 4.
- Wrap: fill dst = 62, len = 4, fill_val = 0xA5 → writes at 62, 63, 0, 1.
- len = 0, and a copy with len = 64 and src = 0, dst = 1 → done the cycle after accept, no mem_we; err pulses only for the second. A start pulse while busy is ignored.
- Reset asserted during the WAIT of the 2nd word of a 4-word copy → next cycle mem_we = 0, busy = 0, no done; only the 1st destination word was written.
